ex_hazard_unit: RTL and testbench

Hazard and forwarding controller on the consumer side of the ID/EX pipeline register in the 8-bit pipelined processor. It reads the registered ID/EX outputs and the decode-stage source addresses. It shadows the EX/MEM and MEM/WB destination info internally and produces the following:
- operand-forwarding selects for the EX-stage ALU
- load-use stall/bubble requests
- a drain-and-halt sequence when the `done` instruction reaches EX

---
 rtl/ex_hazard_unit.sv | 99 +++++++++
 tb/tb_ex_hazard_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_unit.sv
// EX-stage hazard controller: operand forwarding selects, load-use stall/bubble,
// and the drain-and-halt sequence that follows a `done` instruction.
//
// state  | meaning
// RUN    | normal execution, load-use detection active
// DRAIN1 | `done` in MEM, pipeline held
// DRAIN2 | `done` in WB, pipeline held
// HALT   | pipeline drained, held until reset
module ex_hazard_unit #(
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   id_valid_i,
  input  logic [2:0]             id_rs_addr_i,
  input  logic [2:0]             id_rt_addr_i,
  input  logic                   id_uses_rs_i,
  input  logic                   id_uses_rt_i,
  input  logic [2:0]             ex_rs_addr_i,
  input  logic [2:0]             ex_rt_addr_i,
  input  logic [2:0]             ex_write_addr_i,
  input  logic                   ex_regwrite_i,
  input  logic                   ex_memread_i,
  input  logic                   ex_done_i,
  output logic [1:0]             fwd_rs_sel_o,
  output logic [1:0]             fwd_rt_sel_o,
  output logic                   stall_o,
  output logic                   bubble_o,
  output logic                   halted_o,
  output logic [STALL_CNT_W-1:0] stall_count_o
);

  typedef enum logic [1:0] {RUN, DRAIN1, DRAIN2, HALT} state_t;

  state_t     state;
  logic [2:0] mem_wa, wb_wa;
  logic       mem_rw, wb_rw;
  logic       lu;

  // Shadow copies of the downstream destinations; bubbles arrive here as regwrite=0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_wa <= 3'd0;
      mem_rw <= 1'b0;
      wb_wa  <= 3'd0;
      wb_rw  <= 1'b0;
    end else begin
      mem_wa <= ex_write_addr_i;
      mem_rw <= ex_regwrite_i;
      wb_wa  <= mem_wa;
      wb_rw  <= mem_rw;
    end
  end

  always_comb begin
    fwd_rs_sel_o = 2'b00;
    if (mem_rw && (mem_wa == ex_rs_addr_i))     fwd_rs_sel_o = 2'b01;
    else if (wb_rw && (wb_wa == ex_rs_addr_i))  fwd_rs_sel_o = 2'b10;

    fwd_rt_sel_o = 2'b00;
    if (mem_rw && (mem_wa == ex_rt_addr_i))     fwd_rt_sel_o = 2'b01;
    else if (wb_rw && (wb_wa == ex_rt_addr_i))  fwd_rt_sel_o = 2'b10;
  end

  assign lu = id_valid_i & ex_memread_i & ex_regwrite_i &
              ((id_uses_rs_i & (id_rs_addr_i == ex_write_addr_i)) |
               (id_uses_rt_i & (id_rt_addr_i == ex_write_addr_i)));

  // Outside RUN the pipeline is always held; in RUN only a hazard or `done` holds it.
  assign stall_o  = (state != RUN) | lu | ex_done_i;
  assign bubble_o = stall_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= RUN;
      halted_o      <= 1'b0;
      stall_count_o <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ex_done_i)
            state <= DRAIN1;
          else if (lu && (stall_count_o != '1))
            stall_count_o <= stall_count_o + STALL_CNT_W'(1);
        end
        DRAIN1: state <= DRAIN2;
        DRAIN2: begin
          state    <= HALT;
          halted_o <= 1'b1;
        end
        default: begin
          state    <= HALT;
          halted_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_hazard_unit.sv
// Randomized and directed check of ex_hazard_unit against a history-based
// reference model of the pipeline's destination writes and drain progress.
module tb_ex_hazard_unit;

  localparam int W = 8;
  localparam int CNT_MAX = (1 << W) - 1;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         id_valid_i, id_uses_rs_i, id_uses_rt_i;
  logic [2:0]   id_rs_addr_i, id_rt_addr_i;
  logic [2:0]   ex_rs_addr_i, ex_rt_addr_i, ex_write_addr_i;
  logic         ex_regwrite_i, ex_memread_i, ex_done_i;
  logic [1:0]   fwd_rs_sel_o, fwd_rt_sel_o;
  logic         stall_o, bubble_o, halted_o;
  logic [W-1:0] stall_count_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the last two EX destinations, cycles elapsed since `done`, and stall tally.
  int m_dest_addr [2];
  int m_dest_wr   [2];
  int m_done_age;
  int m_cnt;

  ex_hazard_unit #(.STALL_CNT_W(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .id_valid_i(id_valid_i), .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .ex_rs_addr_i(ex_rs_addr_i), .ex_rt_addr_i(ex_rt_addr_i), .ex_write_addr_i(ex_write_addr_i),
    .ex_regwrite_i(ex_regwrite_i), .ex_memread_i(ex_memread_i), .ex_done_i(ex_done_i),
    .fwd_rs_sel_o(fwd_rs_sel_o), .fwd_rt_sel_o(fwd_rt_sel_o),
    .stall_o(stall_o), .bubble_o(bubble_o), .halted_o(halted_o),
    .stall_count_o(stall_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_sel(input int src);
    // Index 0 is the most recent writer (now in MEM), index 1 the older one (in WB).
    if (m_dest_wr[0] != 0 && m_dest_addr[0] == src) return 1;
    if (m_dest_wr[1] != 0 && m_dest_addr[1] == src) return 2;
    return 0;
  endfunction

  function automatic int m_lu();
    return (id_valid_i && ex_memread_i && ex_regwrite_i &&
            ((id_uses_rs_i && id_rs_addr_i == ex_write_addr_i) ||
             (id_uses_rt_i && id_rt_addr_i == ex_write_addr_i))) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_dest_addr[0] = 0; m_dest_addr[1] = 0;
    m_dest_wr[0]   = 0; m_dest_wr[1]   = 0;
    m_done_age = 0;
    m_cnt = 0;
  endtask

  // Drive at negedge, then compare every output against the model.
  task automatic drv(input logic rst, input logic v, input logic [2:0] rsa, input logic [2:0] rta,
                     input logic urs, input logic urt, input logic [2:0] exrs, input logic [2:0] exrt,
                     input logic [2:0] wa, input logic rw, input logic mr, input logic dn);
    int hold;
    @(negedge clk_i);
    reset_i = rst; id_valid_i = v; id_rs_addr_i = rsa; id_rt_addr_i = rta;
    id_uses_rs_i = urs; id_uses_rt_i = urt; ex_rs_addr_i = exrs; ex_rt_addr_i = exrt;
    ex_write_addr_i = wa; ex_regwrite_i = rw; ex_memread_i = mr; ex_done_i = dn;
    #2;
    hold = (m_done_age != 0 || m_lu() != 0 || ex_done_i) ? 1 : 0;
    chk("fwd_rs", fwd_rs_sel_o, m_sel(ex_rs_addr_i));
    chk("fwd_rt", fwd_rt_sel_o, m_sel(ex_rt_addr_i));
    chk("stall", stall_o, hold);
    chk("bubble", bubble_o, hold);
    chk("halted", halted_o, (m_done_age >= 3) ? 1 : 0);
    chk("count", stall_count_o, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (reset_i) begin
      model_reset();
    end else begin
      if (m_done_age == 0) begin
        if (ex_done_i) m_done_age = 1;
        else if (m_lu() != 0 && m_cnt < CNT_MAX) m_cnt++;
      end else if (m_done_age < 3) begin
        m_done_age++;
      end
      m_dest_addr[1] = m_dest_addr[0]; m_dest_wr[1] = m_dest_wr[0];
      m_dest_addr[0] = ex_write_addr_i; m_dest_wr[0] = ex_regwrite_i;
    end
  endtask

  task automatic idle(input logic rst);
    drv(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_cycle(input int p_done, input int p_rst);
    drv(($urandom_range(99) < p_rst), 1'($urandom), 3'($urandom_range(3)), 3'($urandom_range(3)),
        1'($urandom), 1'($urandom), 3'($urandom_range(3)), 3'($urandom_range(3)),
        3'($urandom_range(3)), 1'($urandom), 1'($urandom), ($urandom_range(99) < p_done));
    tick();
  endtask

  initial begin
    model_reset();
    idle(1); tick();
    idle(1); tick();
    idle(0);
    chk("rst_fwd_rs", fwd_rs_sel_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_count", stall_count_o, 0);
    tick();

    // r3 written in EX, read next cycle (MEM) and the one after (WB).
    drv(0, 0, 0, 0, 0, 0, 0, 0, 3'd3, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 3'd3, 0, 0, 0, 0, 0);
    chk("dir_rs_mem", fwd_rs_sel_o, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 3'd3, 0, 0, 0, 0, 0);
    chk("dir_rs_wb", fwd_rs_sel_o, 2); tick();

    // r5 in both MEM and WB: MEM wins; then only WB still writes r5.
    drv(0, 0, 0, 0, 0, 0, 0, 0, 3'd5, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 3'd5, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 3'd5, 0, 0, 0, 0);
    chk("dir_rt_prio", fwd_rt_sel_o, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 3'd5, 0, 0, 0, 0);
    chk("dir_rt_wb", fwd_rt_sel_o, 2); tick();

    // Load to r2 with a dependent rt reader in ID: one stall, then the bubble.
    drv(0, 1, 0, 3'd2, 0, 1, 0, 0, 3'd2, 1, 1, 0);
    chk("dir_lu_stall", stall_o, 1); tick();
    drv(0, 1, 0, 3'd2, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("dir_lu_once", stall_o, 0);
    chk("dir_lu_count", stall_count_o, 1); tick();
    drv(0, 1, 0, 3'd2, 0, 0, 0, 0, 3'd2, 1, 1, 0);
    chk("dir_lu_nouse", stall_o, 0); tick();

    // Done together with a load-use hit, then drain to halt.
    drv(0, 1, 0, 3'd2, 0, 1, 0, 0, 3'd2, 1, 1, 1);
    chk("done_stall", stall_o, 1); tick();
    idle(0); chk("d1_count", stall_count_o, 1); chk("d1_halt", halted_o, 0); tick();
    idle(0); chk("d2_halt", halted_o, 0); tick();
    idle(0); chk("t3_halt", halted_o, 1); tick();
    for (int i = 0; i < 6; i++) rand_cycle(50, 0);
    idle(0); chk("halt_held", halted_o, 1); tick();

    // Reset pulsed while in DRAIN2.
    idle(1); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    idle(0); tick();
    idle(1); tick();
    idle(0);
    chk("rst_d2_halt", halted_o, 0);
    chk("rst_d2_stall", stall_o, 0);
    chk("rst_d2_sel", fwd_rt_sel_o, 0);
    chk("rst_d2_count", stall_count_o, 0);
    tick();

    // 260 back-to-back load-use events saturate the counter.
    for (int i = 0; i < 260; i++) begin
      drv(0, 1, 3'($urandom), 3'($urandom), 1, 0, 0, 0, 3'd4, 1, 1, 0);
      id_rs_addr_i = 3'd4;
      tick();
    end
    idle(0); chk("sat_count", stall_count_o, CNT_MAX); tick();

    idle(1); tick();
    for (int i = 0; i < 400; i++) rand_cycle(0, 1);
    for (int i = 0; i < 600; i++) rand_cycle(4, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
